param_bit_counter: RTL and testbench

//  Parametrised, self-contained bit counter: counts ones (or zeros, per mode) in a WIDTH-bit word.

---
 rtl/bit_counter_pkg.sv | 15 +
 rtl/bit_counter_datapath.sv | 35 +++
 rtl/param_bit_counter.sv | 62 ++++++
 tb/tb_param_bit_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bit_counter_pkg.sv
// Shared types for the bit counter.
// State encoding and result width helper.
package bit_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bit_counter_datapath.sv
// Shift register and ones counter.
// Loads (optionally inverted) operand, then shifts right while counting.
module bit_counter_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             invert,
  input  logic [WIDTH-1:0] data,
  output logic             z,
  output logic [CNT_W-1:0] result
);

  logic [WIDTH-1:0] a;

  // Load clears the count; shift consumes one LSB per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a      <= '0;
      result <= '0;
    end else if (load) begin
      a      <= invert ? ~data : data;
      result <= '0;
    end else if (shift) begin
      a      <= a >> 1;
      result <= result + CNT_W'(a[0]);
    end
  end

  assign z = (a == '0);

endmodule

// File: rtl/param_bit_counter.sv
// Population counter with start/done handshake.
// FSM sequences the shift datapath with early exit on zero.
module param_bit_counter
  import bit_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             count_zeros,
  input  logic [WIDTH-1:0] data_in,
  output logic [CNT_W-1:0] result,
  output logic             busy,
  output logic             done
);

  state_t ps;
  state_t ns;
  logic   z;
  logic   load;
  logic   shift;

  assign load  = (ps == IDLE);
  assign shift = (ps == SHIFT) && !z;

  bit_counter_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .shift  (shift),
    .invert (count_zeros),
    .data   (data_in),
    .z      (z),
    .result (result)
  );

  // Next-state decode.
  always_comb begin
    ns = ps;
    unique case (ps)
      IDLE:    ns = start ? SHIFT : IDLE;
      SHIFT:   ns = z ? DONE : SHIFT;
      DONE:    ns = start ? DONE : IDLE;
      default: ns = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) ps <= IDLE;
    else       ps <= ns;
  end

  assign busy = (ps == SHIFT);
  assign done = (ps == DONE);

endmodule

// File: tb/tb_param_bit_counter.sv
// Scoreboarded bench for param_bit_counter.
// Drives 8- and 16-bit instances side by side.
module tb_param_bit_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start8, cz8;
  logic [7:0]  d8;
  logic [3:0]  r8;
  logic        busy8, done8;
  logic        start16, cz16;
  logic [15:0] d16;
  logic [4:0]  r16;
  logic        busy16, done16;

  param_bit_counter #(.WIDTH(8)) u8 (
    .clk         (clk),
    .reset       (reset),
    .start       (start8),
    .count_zeros (cz8),
    .data_in     (d8),
    .result      (r8),
    .busy        (busy8),
    .done        (done8)
  );

  param_bit_counter #(.WIDTH(16)) u16 (
    .clk         (clk),
    .reset       (reset),
    .start       (start16),
    .count_zeros (cz16),
    .data_in     (d16),
    .result      (r16),
    .busy        (busy16),
    .done        (done16)
  );

  typedef struct {
    int res;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(int w, logic [15:0] d, logic m);
    exp_t        e;
    logic [15:0] a;
    a = m ? ~d : d;
    e.res = 0;
    e.lat = 1;
    for (int i = 0; i < w; i++)
      if (a[i]) begin
        e.res++;
        e.lat = i + 2;
      end
    return e;
  endfunction

  function automatic logic cur_busy(bit w);
    return w ? busy16 : busy8;
  endfunction

  function automatic logic cur_done(bit w);
    return w ? done16 : done8;
  endfunction

  function automatic logic [31:0] cur_res(bit w);
    return w ? 32'(r16) : 32'(r8);
  endfunction

  task automatic drive(bit w, logic [15:0] d, logic m, logic s);
    if (w) begin
      d16 = d; cz16 = m; start16 = s;
    end else begin
      d8 = d[7:0]; cz8 = m; start8 = s;
    end
  endtask

  task automatic run_op(bit w, logic [15:0] d, logic m,
                        int hold, bit scramble);
    exp_t e;
    int   edges = 0;
    int   bcnt  = 0;
    int   both  = 0;
    bit   seen  = 0;
    sb.push_back(model(w ? 16 : 8, d, m));
    @(negedge clk);
    drive(w, d, m, 1'b1);
    @(posedge clk);
    #1;
    if (cur_busy(w)) bcnt++;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
      if (cur_busy(w) && cur_done(w)) both++;
      if (cur_done(w)) begin
        seen = 1;
        break;
      end
      if (cur_busy(w)) bcnt++;
      if (scramble) drive(w, 16'($urandom), 1'($urandom), 1'b0);
    end
    e = sb.pop_front();
    check("done_seen", 32'(seen), 32'd1);
    check("latency", edges, e.lat);
    check("busy_cycles", bcnt, e.lat);
    check("busy_done_excl", both, 0);
    check("result", cur_res(w), e.res);
    for (int i = 0; i < hold; i++) begin
      drive(w, 16'($urandom), 1'($urandom), 1'b1);
      @(posedge clk);
      #1;
      check("hold_done", 32'(cur_done(w)), 32'd1);
      check("hold_result", cur_res(w), e.res);
    end
    drive(w, d, m, 1'b0);
    @(posedge clk);
    #1;
    check("release_done", 32'(cur_done(w)), 32'd0);
    check("release_busy", 32'(cur_busy(w)), 32'd0);
    @(posedge clk);
    #1;
    check("idle_result", cur_res(w), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_res8", 32'(r8), 32'd0);
    check("rst_res16", 32'(r16), 32'd0);
    reset = 1'b0;

    // reset during SHIFT
    @(negedge clk);
    drive(1'b0, 16'h00FF, 1'b0, 1'b1);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy8), 32'd1);
    reset  = 1'b1;
    start8 = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_busy", 32'(busy8), 32'd0);
    check("mrst_done", 32'(done8), 32'd0);
    check("mrst_res", 32'(r8), 32'd0);
    reset = 1'b0;
    @(posedge clk);

    run_op(1'b0, 16'h00B4, 1'b0, 0, 1'b0);
    run_op(1'b0, 16'h0000, 1'b0, 0, 1'b0);
    run_op(1'b0, 16'h00F0, 1'b1, 0, 1'b0);
    run_op(1'b0, 16'h005A, 1'b0, 5, 1'b1);
    run_op(1'b0, 16'h00FF, 1'b1, 0, 1'b0);
    run_op(1'b0, 16'h0001, 1'b0, 0, 1'b0);
    run_op(1'b0, 16'h0080, 1'b0, 1, 1'b0);
    run_op(1'b1, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op(1'b1, 16'h0000, 1'b1, 2, 1'b1);
    for (int k = 0; k < 6; k++)
      run_op(1'($urandom), 16'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
